// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-Lite to APB3 bridge.
//   bridge_state_e : bridge FSM encoding
//   HTRANS_*       : AHB transfer-type codes
//   HRESP_*        : AHB response codes
//   size_to_strb   : byte-lane mask for a transfer of a given Hsize at a lane offset
package bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } bridge_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   // Mask covers up to 8 lanes; callers keep the low DATA_W/8 bits.
   // Offset is aligned down to the transfer size before shifting.
   function automatic logic [7:0] size_to_strb(input logic [2:0] size,
                                               input logic [2:0] offset);
      logic [7:0] base;
      logic [2:0] align;
      case (size)
         3'd0:    base = 8'h01;
         3'd1:    base = 8'h03;
         3'd2:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      align = offset & ~((3'd1 << size) - 3'd1);
      return base << align;
   endfunction

endpackage

// File: rtl/bridge_apb_decoder.sv
// Address decoder for the AHB-APB bridge.
//   addr    : Haddr bits from REGION_LSB upwards
//   sel     : one-hot slave select (all zero when the address misses)
//   addr_ok : bits above the slave-index field match BASE_ADDR
module bridge_apb_decoder #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       NUM_SLV    = 4,
   parameter int unsigned       REGION_LSB = 28,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000
) (
   input  logic [ADDR_W-1:REGION_LSB] addr,
   output logic [NUM_SLV-1:0]         sel,
   output logic                       addr_ok
);

   localparam int unsigned IDX_W   = $clog2(NUM_SLV);
   localparam int unsigned TOP_LSB = REGION_LSB + IDX_W;

   logic [IDX_W-1:0] idx;

   assign idx     = addr[REGION_LSB +: IDX_W];
   assign addr_ok = (addr[ADDR_W-1:TOP_LSB] == BASE_ADDR[ADDR_W-1:TOP_LSB]);

   always_comb begin
      sel = '0;
      if (addr_ok)
         sel[idx] = 1'b1;
   end

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// AHB-Lite to APB3 bridge. Each AHB beat becomes one APB transfer to one of
// NUM_SLV slaves; adds Pready wait states, Pslverr -> ERROR mapping and
// address/size decode errors (two-cycle ERROR response, no APB access).
// Optional macro APB_PSTRB_EN adds the Pstrb output (write byte lanes).
//   AHB side : Haddr, Htrans, Hwrite, Hsize, Hburst (ignored), Hwdata,
//              Hreadyin -> Hrdata, Hreadyout, Hresp
//   APB side : Psel, Penable, Pwrite, Paddr, Pwdata [, Pstrb]
//              <- Prdata, Pready, Pslverr
module ahb_apb_bridge_p
   import bridge_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       NUM_SLV    = 4,
   parameter int unsigned       REGION_LSB = 28,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000
) (
   input  logic                clk,
   input  logic                Hresetn,
   input  logic [ADDR_W-1:0]   Haddr,
   input  logic [1:0]          Htrans,
   input  logic                Hwrite,
   input  logic [2:0]          Hsize,
   input  logic [2:0]          Hburst,
   input  logic [DATA_W-1:0]   Hwdata,
   input  logic                Hreadyin,
   output logic [DATA_W-1:0]   Hrdata,
   output logic                Hreadyout,
   output logic [1:0]          Hresp,
   output logic [NUM_SLV-1:0]  Psel,
   output logic                Penable,
   output logic                Pwrite,
   output logic [ADDR_W-1:0]   Paddr,
   output logic [DATA_W-1:0]   Pwdata,
   input  logic [DATA_W-1:0]   Prdata,
   input  logic                Pready,
   input  logic                Pslverr
`ifdef APB_PSTRB_EN
   ,
   output logic [DATA_W/8-1:0] Pstrb
`endif
);

   localparam int unsigned NB     = DATA_W / 8;
   localparam int unsigned LANE_W = $clog2(NB);

   bridge_state_e state, state_nx, accept_nx;

   logic [NUM_SLV-1:0] dec_sel, sel_q;
   logic               dec_ok, size_ok, acc_done, accept;

   bridge_apb_decoder #(
      .ADDR_W     (ADDR_W),
      .NUM_SLV    (NUM_SLV),
      .REGION_LSB (REGION_LSB),
      .BASE_ADDR  (BASE_ADDR)
   ) u_dec (
      .addr    (Haddr[ADDR_W-1:REGION_LSB]),
      .sel     (dec_sel),
      .addr_ok (dec_ok)
   );

   assign size_ok  = (Hsize <= 3'(LANE_W));
   assign acc_done = (state == ST_ACCESS) && Pready && !Pslverr;
   assign accept   = Hreadyin && Htrans[1] &&
                     ((state == ST_IDLE) || (state == ST_ERR2) || acc_done);

   always_comb begin
      if (!(dec_ok && size_ok)) accept_nx = ST_ERR1;
      else if (Hwrite)          accept_nx = ST_WDATA;
      else                      accept_nx = ST_SETUP;
   end

   always_ff @(posedge clk or negedge Hresetn) begin
      if (!Hresetn) state <= ST_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      Hreadyout = 1'b1;
      Hresp     = HRESP_OKAY;
      Hrdata    = '0;
      case (state)
         ST_IDLE:   state_nx = accept ? accept_nx : ST_IDLE;
         ST_WDATA: begin
            Hreadyout = 1'b0;
            state_nx  = ST_SETUP;
         end
         ST_SETUP: begin
            Hreadyout = 1'b0;
            state_nx  = ST_ACCESS;
         end
         ST_ACCESS: begin
            Hreadyout = 1'b0;
            if (Pready) begin
               if (Pslverr) begin
                  state_nx = ST_ERR1;
               end else begin
                  Hreadyout = 1'b1;
                  if (!Pwrite) Hrdata = Prdata;
                  state_nx = accept ? accept_nx : ST_IDLE;
               end
            end
         end
         ST_ERR1: begin
            Hreadyout = 1'b0;
            Hresp     = HRESP_ERROR;
            state_nx  = ST_ERR2;
         end
         ST_ERR2: begin
            Hresp    = HRESP_ERROR;
            state_nx = accept ? accept_nx : ST_IDLE;
         end
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Address-phase values are only replaced on accept, which never happens
   // while an access is stalled, so Paddr/Pwrite/Psel stay stable under Pready=0.
   always_ff @(posedge clk or negedge Hresetn) begin
      if (!Hresetn) begin
         Paddr  <= '0;
         Pwrite <= 1'b0;
         Pwdata <= '0;
         sel_q  <= '0;
      end else begin
         if (accept) begin
            Paddr  <= Haddr;
            Pwrite <= Hwrite;
            sel_q  <= dec_sel;
         end
         if (state == ST_WDATA)
            Pwdata <= Hwdata;
      end
   end

   assign Psel    = ((state == ST_SETUP) || (state == ST_ACCESS)) ? sel_q : '0;
   assign Penable = (state == ST_ACCESS);

`ifdef APB_PSTRB_EN
   logic [2:0] lane_off;
   logic [7:0] strb_all;

   always_comb begin
      lane_off             = '0;
      lane_off[LANE_W-1:0] = Haddr[LANE_W-1:0];
      strb_all             = size_to_strb(Hsize, lane_off);
   end

   always_ff @(posedge clk or negedge Hresetn) begin
      if (!Hresetn)    Pstrb <= '0;
      else if (accept) Pstrb <= Hwrite ? strb_all[NB-1:0] : '0;
   end

   logic unused_ok;
   assign unused_ok = ^{Hburst, Htrans[0], strb_all};
`else
   logic unused_ok;
   assign unused_ok = ^{Hburst, Htrans[0]};
`endif

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
module tb_ahb_apb_bridge_p;

   logic        clk;
   logic        Hresetn;
   logic [31:0] Haddr;
   logic [1:0]  Htrans;
   logic        Hwrite;
   logic [2:0]  Hsize;
   logic [2:0]  Hburst;
   logic [31:0] Hwdata;
   logic        Hreadyin;
   logic [31:0] Hrdata;
   logic        Hreadyout;
   logic [1:0]  Hresp;
   logic [3:0]  Psel;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata;
   logic        Pready;
   logic        Pslverr;
`ifdef APB_PSTRB_EN
   logic [3:0]  Pstrb;
`endif

   assign Hreadyin = Hreadyout;

   ahb_apb_bridge_p #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .NUM_SLV    (4),
      .REGION_LSB (28),
      .BASE_ADDR  (32'h8000_0000)
   ) dut (
      .clk       (clk),
      .Hresetn   (Hresetn),
      .Haddr     (Haddr),
      .Htrans    (Htrans),
      .Hwrite    (Hwrite),
      .Hsize     (Hsize),
      .Hburst    (Hburst),
      .Hwdata    (Hwdata),
      .Hreadyin  (Hreadyin),
      .Hrdata    (Hrdata),
      .Hreadyout (Hreadyout),
      .Hresp     (Hresp),
      .Psel      (Psel),
      .Penable   (Penable),
      .Pwrite    (Pwrite),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata),
      .Prdata    (Prdata),
      .Pready    (Pready),
      .Pslverr   (Pslverr)
`ifdef APB_PSTRB_EN
      ,
      .Pstrb     (Pstrb)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [3:0]  strb;
   } apb_t;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  resp;
   } ahb_t;

   apb_t        apb_q[$];
   ahb_t        ahb_q[$];
   int          comp_cyc[$];
   int          checks = 0;
   int          fails  = 0;
   int          cyc    = 0;
   int          psel_cycles = 0;
   int unsigned slv_waits = 0;
   logic        slv_err   = 1'b0;
   logic [31:0] slv_rdata = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   // APB slave: Pready after slv_waits wait cycles; during waits it drives
   // Pslverr=1 and junk read data, which the bridge must ignore.
   initial begin
      int unsigned cnt;
      cnt = 0;
      Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (Psel != 4'b0 && Penable) begin
            if (cnt >= slv_waits) begin
               Pready = 1'b1; Pslverr = slv_err; Prdata = slv_rdata;
            end else begin
               Pready = 1'b0; Pslverr = 1'b1; Prdata = 32'hBAD0_BAD0;
               cnt++;
            end
         end else begin
            Pready = 1'b0; Pslverr = 1'b0; Prdata = '0; cnt = 0;
         end
      end
   end

   // APB monitor: stability through wait states and scoreboard of completed transfers.
   initial begin
      logic [68:0] snap;
      apb_t        e;
      snap = '0;
      forever begin
         @(negedge clk);
         if (Hresetn && Psel != 4'b0) begin
            psel_cycles++;
            if (!Penable) begin
               snap = {Paddr, Pwrite, Psel, Pwdata};
            end else begin
               checks++;
               if ({Paddr, Pwrite, Psel, Pwdata} !== snap) begin
                  fails++;
                  $display("FAIL apb_stable: got %h required %h", {Paddr, Pwrite, Psel, Pwdata}, snap);
               end
               if (Pready) begin
                  comp_cyc.push_back(cyc);
                  checks++;
                  if (apb_q.size() == 0) begin
                     fails++;
                     $display("FAIL apb_unexpected: transfer to %h with none expected", Paddr);
                  end else begin
                     e = apb_q.pop_front();
                     if (Paddr !== e.addr || Pwrite !== e.wr || Psel !== e.sel ||
                         (e.wr && Pwdata !== e.wdata)) begin
                        fails++;
                        $display("FAIL apb_xfer: got addr=%h wr=%b sel=%b wdata=%h required addr=%h wr=%b sel=%b wdata=%h",
                                 Paddr, Pwrite, Psel, Pwdata, e.addr, e.wr, e.sel, e.wdata);
                     end
`ifdef APB_PSTRB_EN
                     checks++;
                     if (Pstrb !== e.strb) begin
                        fails++;
                        $display("FAIL apb_pstrb: got %b required %b", Pstrb, e.strb);
                     end
`endif
                  end
               end
            end
         end
      end
   end

   function automatic logic [3:0] exp_strb(input logic [2:0] size, input logic [1:0] off,
                                           input logic wr);
      if (!wr) return 4'b0000;
      case (size)
         3'd0:    return 4'b0001 << off;
         3'd1:    return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic apb_t mk_apb(input logic [31:0] addr, input logic wr,
                                   input logic [2:0] size, input logic [31:0] wdata);
      apb_t p;
      p.addr  = addr;
      p.wr    = wr;
      p.wdata = wdata;
      p.sel   = 4'b0001 << addr[29:28];
      p.strb  = exp_strb(size, addr[1:0], wr);
      return p;
   endfunction

   // Single AHB transfer; called at a negedge when the bridge can accept.
   // Returns the number of cycles until Hreadyout and the response seen then.
   task automatic ahb_drive(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [31:0] wdata, output int n, output logic [1:0] resp,
                            output logic [31:0] rdata, output logic saw_err1);
      Htrans = 2'b10; Haddr = addr; Hwrite = wr; Hsize = size; Hburst = 3'b000;
      @(negedge clk);
      Htrans = 2'b00; Hwdata = wdata;
      n = 1; saw_err1 = 1'b0;
      while (!Hreadyout && n < 100) begin
         if (Hresp == 2'b01) saw_err1 = 1'b1;
         @(negedge clk);
         n++;
      end
      resp = Hresp; rdata = Hrdata;
   endtask

   task automatic test_reset;
      Hresetn = 1'b0; Htrans = 2'b00; Haddr = '0; Hwrite = 1'b0; Hsize = 3'd2;
      Hburst = 3'b000; Hwdata = '0;
      repeat (3) @(negedge clk);
      checks++; if (Psel !== 4'b0)    begin fails++; $display("FAIL reset_psel: got %b required 0000", Psel); end
      checks++; if (Penable !== 1'b0) begin fails++; $display("FAIL reset_penable: got %b required 0", Penable); end
      checks++; if (Pwrite !== 1'b0)  begin fails++; $display("FAIL reset_pwrite: got %b required 0", Pwrite); end
      checks++; if (Paddr !== '0)     begin fails++; $display("FAIL reset_paddr: got %h required 0", Paddr); end
      checks++; if (Pwdata !== '0)    begin fails++; $display("FAIL reset_pwdata: got %h required 0", Pwdata); end
      checks++; if (Hreadyout !== 1'b1) begin fails++; $display("FAIL reset_hreadyout: got %b required 1", Hreadyout); end
      checks++; if (Hresp !== 2'b00)  begin fails++; $display("FAIL reset_hresp: got %b required 00", Hresp); end
      checks++; if (Hrdata !== '0)    begin fails++; $display("FAIL reset_hrdata: got %h required 0", Hrdata); end
`ifdef APB_PSTRB_EN
      checks++; if (Pstrb !== 4'b0)   begin fails++; $display("FAIL reset_pstrb: got %b required 0000", Pstrb); end
`endif
      Hresetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read;
      int n; logic [1:0] resp; logic [31:0] rd; logic se; ahb_t a;
      slv_waits = 0; slv_err = 1'b0; slv_rdata = 32'hDEAD_BEEF;
      apb_q.push_back(mk_apb(32'h9000_0010, 1'b0, 3'd2, 32'h0));
      ahb_q.push_back('{rdata: 32'hDEAD_BEEF, resp: 2'b00});
      ahb_drive(32'h9000_0010, 1'b0, 3'd2, 32'h0, n, resp, rd, se);
      a = ahb_q.pop_front();
      checks++; if (n !== 2)        begin fails++; $display("FAIL read_latency: got %0d required 2", n); end
      checks++; if (resp !== a.resp) begin fails++; $display("FAIL read_resp: got %b required %b", resp, a.resp); end
      checks++; if (rd !== a.rdata) begin fails++; $display("FAIL read_rdata: got %h required %h", rd, a.rdata); end
      // two-wait read to slave 3
      slv_waits = 2; slv_rdata = 32'h0BAD_CAFE;
      apb_q.push_back(mk_apb(32'hB000_0008, 1'b0, 3'd2, 32'h0));
      ahb_q.push_back('{rdata: 32'h0BAD_CAFE, resp: 2'b00});
      ahb_drive(32'hB000_0008, 1'b0, 3'd2, 32'h0, n, resp, rd, se);
      a = ahb_q.pop_front();
      checks++; if (n !== 4)        begin fails++; $display("FAIL read_wait_latency: got %0d required 4", n); end
      checks++; if (rd !== a.rdata) begin fails++; $display("FAIL read_wait_rdata: got %h required %h", rd, a.rdata); end
      @(negedge clk);
      checks++; if (Hrdata !== '0)  begin fails++; $display("FAIL idle_hrdata: got %h required 0", Hrdata); end
   endtask

   task automatic test_write_wait;
      int n; logic [1:0] resp; logic [31:0] rd; logic se; ahb_t a;
      slv_waits = 3; slv_err = 1'b0;
      apb_q.push_back(mk_apb(32'h8000_0004, 1'b1, 3'd2, 32'hA5A5_A5A5));
      ahb_q.push_back('{rdata: 32'h0, resp: 2'b00});
      ahb_drive(32'h8000_0004, 1'b1, 3'd2, 32'hA5A5_A5A5, n, resp, rd, se);
      a = ahb_q.pop_front();
      checks++; if (n !== 6)         begin fails++; $display("FAIL write_latency: got %0d required 6", n); end
      checks++; if (resp !== a.resp) begin fails++; $display("FAIL write_resp: got %b required %b", resp, a.resp); end
      checks++; if (rd !== a.rdata)  begin fails++; $display("FAIL write_hrdata: got %h required %h", rd, a.rdata); end
   endtask

   task automatic test_subword_write;
      int n; logic [1:0] resp; logic [31:0] rd; logic se;
      slv_waits = 0; slv_err = 1'b0;
      apb_q.push_back(mk_apb(32'h8000_0002, 1'b1, 3'd1, 32'h1234_0000));
      ahb_drive(32'h8000_0002, 1'b1, 3'd1, 32'h1234_0000, n, resp, rd, se);
      checks++; if (n !== 3) begin fails++; $display("FAIL half_latency: got %0d required 3", n); end
      apb_q.push_back(mk_apb(32'h8000_0003, 1'b1, 3'd0, 32'h5600_0000));
      ahb_drive(32'h8000_0003, 1'b1, 3'd0, 32'h5600_0000, n, resp, rd, se);
      checks++; if (resp !== 2'b00) begin fails++; $display("FAIL byte_resp: got %b required 00", resp); end
   endtask

   task automatic test_slverr;
      int n; logic [1:0] resp; logic [31:0] rd; logic se; ahb_t a;
      slv_waits = 0; slv_err = 1'b1; slv_rdata = 32'hFFFF_0000;
      apb_q.push_back(mk_apb(32'h8000_0020, 1'b0, 3'd2, 32'h0));
      ahb_q.push_back('{rdata: 32'h0, resp: 2'b01});
      ahb_drive(32'h8000_0020, 1'b0, 3'd2, 32'h0, n, resp, rd, se);
      a = ahb_q.pop_front();
      checks++; if (n !== 4)         begin fails++; $display("FAIL slverr_latency: got %0d required 4", n); end
      checks++; if (resp !== a.resp) begin fails++; $display("FAIL slverr_resp: got %b required %b", resp, a.resp); end
      checks++; if (se !== 1'b1)     begin fails++; $display("FAIL slverr_first_cycle: got %b required 1", se); end
      checks++; if (rd !== a.rdata)  begin fails++; $display("FAIL slverr_hrdata: got %h required %h", rd, a.rdata); end
      // next beat launched while the bridge sits in ERR2
      slv_err = 1'b0; slv_rdata = 32'h1234_5678;
      apb_q.push_back(mk_apb(32'h9000_0000, 1'b0, 3'd2, 32'h0));
      ahb_q.push_back('{rdata: 32'h1234_5678, resp: 2'b00});
      ahb_drive(32'h9000_0000, 1'b0, 3'd2, 32'h0, n, resp, rd, se);
      a = ahb_q.pop_front();
      checks++; if (n !== 2)        begin fails++; $display("FAIL err2_accept_latency: got %0d required 2", n); end
      checks++; if (rd !== a.rdata) begin fails++; $display("FAIL err2_accept_rdata: got %h required %h", rd, a.rdata); end
   endtask

   task automatic test_decode_err;
      int n; int p0; logic [1:0] resp; logic [31:0] rd; logic se; ahb_t a;
      slv_waits = 0; slv_err = 1'b0;
      p0 = psel_cycles;
      ahb_q.push_back('{rdata: 32'h0, resp: 2'b01});
      ahb_drive(32'h1000_0000, 1'b0, 3'd2, 32'h0, n, resp, rd, se);
      a = ahb_q.pop_front();
      checks++; if (n !== 2)         begin fails++; $display("FAIL decerr_latency: got %0d required 2", n); end
      checks++; if (resp !== a.resp) begin fails++; $display("FAIL decerr_resp: got %b required %b", resp, a.resp); end
      checks++; if (se !== 1'b1)     begin fails++; $display("FAIL decerr_first_cycle: got %b required 1", se); end
      // oversize beat (doubleword on a 32-bit bus) at a valid address
      ahb_q.push_back('{rdata: 32'h0, resp: 2'b01});
      ahb_drive(32'h8000_0000, 1'b1, 3'd3, 32'h7777_7777, n, resp, rd, se);
      a = ahb_q.pop_front();
      checks++; if (n !== 2 || resp !== a.resp) begin
         fails++; $display("FAIL size_err: got n=%0d resp=%b required n=2 resp=%b", n, resp, a.resp);
      end
      checks++; if (psel_cycles - p0 !== 0) begin
         fails++; $display("FAIL decerr_no_psel: got %0d psel cycles required 0", psel_cycles - p0);
      end
   endtask

   task automatic test_idle_busy;
      Htrans = 2'b01; Haddr = 32'h8000_0000; Hwrite = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         Htrans = (i == 0) ? 2'b00 : 2'b01;
         checks++;
         if (Hreadyout !== 1'b1 || Hresp !== 2'b00 || Psel !== 4'b0 || Hrdata !== '0) begin
            fails++;
            $display("FAIL idle_busy: got rdy=%b resp=%b psel=%b hrdata=%h required rdy=1 resp=00 psel=0000 hrdata=0",
                     Hreadyout, Hresp, Psel, Hrdata);
         end
      end
      Htrans = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [31:0] addr [4];
      logic [31:0] data [4];
      int dp, ap, done, sz;
      logic r;
      ahb_t a;
      slv_waits = 0; slv_err = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addr[i] = 32'hA000_0000 + 32'(4 * i);
         data[i] = 32'h1111_0000 + 32'(i);
         apb_q.push_back(mk_apb(addr[i], 1'b1, 3'd2, data[i]));
         ahb_q.push_back('{rdata: 32'h0, resp: 2'b00});
      end
      Htrans = 2'b10; Haddr = addr[0]; Hwrite = 1'b1; Hsize = 3'd2; Hburst = 3'b011;
      dp = -1; ap = 0; done = 0;
      for (int k = 0; k < 200; k++) begin
         r = Hreadyout;
         if (r && dp >= 0) begin
            a = ahb_q.pop_front();
            done++;
            checks++;
            if (Hresp !== a.resp || Hrdata !== a.rdata) begin
               fails++;
               $display("FAIL burst_beat%0d: got resp=%b hrdata=%h required resp=%b hrdata=%h",
                        dp, Hresp, Hrdata, a.resp, a.rdata);
            end
         end
         @(negedge clk);
         if (r) begin
            if (ap < 4) begin
               dp = ap; ap++; Hwdata = data[dp];
            end else begin
               dp = -1;
            end
            if (ap < 4) begin Htrans = 2'b11; Haddr = addr[ap]; end
            else        Htrans = 2'b00;
         end
         if (dp < 0 && ap >= 4) break;
      end
      Hburst = 3'b000;
      checks++; if (done !== 4) begin fails++; $display("FAIL burst_beats: got %0d required 4", done); end
      sz = comp_cyc.size();
      checks++;
      if (sz < 4) begin
         fails++; $display("FAIL burst_gap: got %0d completions required 4", sz);
      end else if (comp_cyc[sz-1] - comp_cyc[sz-4] !== 9) begin
         fails++; $display("FAIL burst_gap: got %0d cycles first-to-last required 9", comp_cyc[sz-1] - comp_cyc[sz-4]);
      end
   endtask

   task automatic test_reset_abort;
      int n; logic [1:0] resp; logic [31:0] rd; logic se; ahb_t a;
      slv_waits = 10; slv_err = 1'b0;
      Htrans = 2'b10; Haddr = 32'h8000_0000; Hwrite = 1'b0; Hsize = 3'd2;
      @(negedge clk);
      Htrans = 2'b00;
      n = 0;
      while (!Penable && n < 10) begin @(negedge clk); n++; end
      checks++; if (Penable !== 1'b1) begin fails++; $display("FAIL abort_reach_access: got %b required 1", Penable); end
      #2 Hresetn = 1'b0;
      #1;
      checks++;
      if (Psel !== 4'b0 || Penable !== 1'b0 || Hreadyout !== 1'b1 || Hresp !== 2'b00) begin
         fails++;
         $display("FAIL abort_async: got psel=%b pen=%b rdy=%b resp=%b required 0000 0 1 00",
                  Psel, Penable, Hreadyout, Hresp);
      end
      @(negedge clk);
      Hresetn = 1'b1;
      @(negedge clk);
      slv_waits = 0; slv_rdata = 32'hCAFE_F00D;
      apb_q.push_back(mk_apb(32'hA000_0004, 1'b0, 3'd2, 32'h0));
      ahb_q.push_back('{rdata: 32'hCAFE_F00D, resp: 2'b00});
      ahb_drive(32'hA000_0004, 1'b0, 3'd2, 32'h0, n, resp, rd, se);
      a = ahb_q.pop_front();
      checks++;
      if (n !== 2 || resp !== a.resp || rd !== a.rdata) begin
         fails++;
         $display("FAIL post_reset_read: got n=%0d resp=%b rdata=%h required n=2 resp=%b rdata=%h",
                  n, resp, rd, a.resp, a.rdata);
      end
   endtask

   initial begin
      test_reset;
      test_read;
      test_write_wait;
      test_subword_write;
      test_slverr;
      test_decode_err;
      test_idle_busy;
      test_back_to_back;
      test_reset_abort;
      repeat (3) @(negedge clk);
      checks++;
      if (apb_q.size() != 0) begin
         fails++; $display("FAIL apb_leftover: got %0d pending required 0", apb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
